// File: rtl/mu0_control.sv
// ---------------------------------------------------------------------------
// mu0_control
//
// Control unit for the MU0 processor. Sequences each instruction through a
// FETCH/EXEC pair, drives the datapath mux selects, register enables and ALU
// function, and owns the memory handshake (Rd/Wr/Mem_Rdy).
//
// A watchdog counts consecutive cycles a memory request waits for Mem_Rdy.
// The wait that brings the count to TIMEOUT_CYCLES sends the machine to the
// sticky ERROR state. TIMEOUT_CYCLES = 0 disables the watchdog.
//
// Optional build feature, macro MU0_SINGLE_STEP_EN:
//   Adds the Step input and a PAUSE state. Every completed instruction
//   parks in PAUSE until Step is sampled high. STP still goes to HALT.
//   Without the macro, EXEC returns straight to FETCH.
// ---------------------------------------------------------------------------
module mu0_control #(
   parameter int unsigned TIMEOUT_CYCLES = 15,
   // TO_W must be wide enough that 2**TO_W > TIMEOUT_CYCLES
   parameter int unsigned TO_W           = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [3:0] F,
   input  logic       N,
   input  logic       Z,
   input  logic       Mem_Rdy,
`ifdef MU0_SINGLE_STEP_EN
   input  logic       Step,
`endif
   output logic       X_sel,
   output logic       Y_sel,
   output logic       Addr_sel,
   output logic       PC_En,
   output logic       IR_En,
   output logic       Acc_En,
   output logic [1:0] M,
   output logic       Rd,
   output logic       Wr,
   output logic       Halted,
   output logic       Bus_Err
);

   // Machine states. PAUSE is only reachable in single-step builds.
   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_EXEC  = 3'd1,
      S_HALT  = 3'd2,
      S_ERROR = 3'd3,
      S_PAUSE = 3'd4
   } state_e;

   // Opcodes as seen on F (IR[15:12]); 8..F are all NOPs.
   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_STA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_JMP = 4'h4;
   localparam logic [3:0] OP_JGE = 4'h5;
   localparam logic [3:0] OP_JNE = 4'h6;
   localparam logic [3:0] OP_STP = 4'h7;

   // ALU function codes.
   localparam logic [1:0] ALU_Y   = 2'b00;
   localparam logic [1:0] ALU_ADD = 2'b01;
   localparam logic [1:0] ALU_INC = 2'b10;
   localparam logic [1:0] ALU_SUB = 2'b11;

   // Where a finished instruction goes next.
`ifdef MU0_SINGLE_STEP_EN
   localparam state_e EXEC_DONE = S_PAUSE;
`else
   localparam state_e EXEC_DONE = S_FETCH;
`endif

   state_e            state_q;
   state_e            state_d;
   logic [TO_W-1:0]   wait_cnt_q;
   logic [TO_W-1:0]   wait_cnt_d;
   logic [TO_W-1:0]   wait_cnt_inc;
   logic              is_mem_op;
   logic              mem_req;
   logic              mem_wait;
   logic              timeout_hit;
   logic              step_go;

   // Single-step release: without the feature this is never consulted.
`ifdef MU0_SINGLE_STEP_EN
   always_comb begin
      step_go = Step;
   end
`else
   always_comb begin
      step_go = 1'b0;
   end
`endif

   // Classify the current opcode and decide whether a memory request is live.
   always_comb begin
      is_mem_op = (F == OP_LDA) || (F == OP_STA) ||
                  (F == OP_ADD) || (F == OP_SUB);
      mem_req   = (state_q == S_FETCH) ||
                  ((state_q == S_EXEC) && is_mem_op);
      mem_wait  = mem_req && !Mem_Rdy;
   end

   // Watchdog: saturating increment, and detection of the expiring wait.
   // Mem_Rdy in the threshold cycle wins because mem_wait requires it low.
   always_comb begin
      if (&wait_cnt_q) begin
         wait_cnt_inc = wait_cnt_q;
      end else begin
         wait_cnt_inc = wait_cnt_q + TO_W'(1);
      end
      timeout_hit = (TIMEOUT_CYCLES != 0) && mem_wait &&
                    (wait_cnt_inc == TO_W'(TIMEOUT_CYCLES));
   end

   // Next-state selection.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (Mem_Rdy) begin
               state_d = S_EXEC;
            end else if (timeout_hit) begin
               state_d = S_ERROR;
            end
         end
         S_EXEC: begin
            if (is_mem_op) begin
               if (Mem_Rdy) begin
                  state_d = EXEC_DONE;
               end else if (timeout_hit) begin
                  state_d = S_ERROR;
               end
            end else if (F == OP_STP) begin
               state_d = S_HALT;
            end else begin
               state_d = EXEC_DONE;
            end
         end
         S_PAUSE: begin
            if (step_go) begin
               state_d = S_FETCH;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         S_ERROR: begin
            state_d = S_ERROR;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Wait counter only accumulates while one access keeps stalling in one state.
   always_comb begin
      if (state_d != state_q) begin
         wait_cnt_d = '0;
      end else if (mem_wait) begin
         wait_cnt_d = wait_cnt_inc;
      end else begin
         wait_cnt_d = '0;
      end
   end

   // State and watchdog registers; reset forces FETCH immediately.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Datapath control decode from state, opcode, flags and Mem_Rdy.
   always_comb begin
      X_sel    = 1'b0;
      Y_sel    = 1'b0;
      Addr_sel = 1'b0;
      PC_En    = 1'b0;
      IR_En    = 1'b0;
      Acc_En   = 1'b0;
      M        = ALU_Y;
      Rd       = 1'b0;
      Wr       = 1'b0;
      Halted   = 1'b0;
      Bus_Err  = 1'b0;
      case (state_q)
         S_FETCH: begin
            // Read the instruction at PC while the ALU forms PC+1.
            Rd     = 1'b1;
            X_sel  = 1'b1;
            M      = ALU_INC;
            IR_En  = Mem_Rdy;
            PC_En  = Mem_Rdy;
         end
         S_EXEC: begin
            case (F)
               OP_LDA: begin
                  Addr_sel = 1'b1;
                  Rd       = 1'b1;
                  Y_sel    = 1'b1;
                  M        = ALU_Y;
                  Acc_En   = Mem_Rdy;
               end
               OP_STA: begin
                  Addr_sel = 1'b1;
                  X_sel    = 1'b0;
                  Wr       = 1'b1;
               end
               OP_ADD: begin
                  Addr_sel = 1'b1;
                  Rd       = 1'b1;
                  X_sel    = 1'b0;
                  Y_sel    = 1'b1;
                  M        = ALU_ADD;
                  Acc_En   = Mem_Rdy;
               end
               OP_SUB: begin
                  Addr_sel = 1'b1;
                  Rd       = 1'b1;
                  X_sel    = 1'b0;
                  Y_sel    = 1'b1;
                  M        = ALU_SUB;
                  Acc_En   = Mem_Rdy;
               end
               OP_JMP: begin
                  Y_sel = 1'b0;
                  M     = ALU_Y;
                  PC_En = 1'b1;
               end
               OP_JGE: begin
                  Y_sel = 1'b0;
                  M     = ALU_Y;
                  PC_En = !N;
               end
               OP_JNE: begin
                  Y_sel = 1'b0;
                  M     = ALU_Y;
                  PC_En = !Z;
               end
               default: begin
                  // STP and NOPs drive nothing.
               end
            endcase
         end
         S_HALT: begin
            Halted = 1'b1;
         end
         S_ERROR: begin
            Bus_Err = 1'b1;
         end
         default: begin
            // PAUSE: everything inactive.
         end
      endcase
   end

endmodule

// File: tb/tb_mu0_control.sv
// ---------------------------------------------------------------------------
// tb_mu0_control
//
// Self-checking bench for mu0_control. A behavioural model predicts the full
// output vector for every driven cycle; predictions are queued when the
// stimulus is applied and compared once the DUT outputs have settled.
// Builds with or without MU0_SINGLE_STEP_EN.
// ---------------------------------------------------------------------------
module tb_mu0_control;

   localparam int TMO = 15;
   localparam int TOW = 4;
`ifdef MU0_SINGLE_STEP_EN
   localparam bit SS = 1'b1;
`else
   localparam bit SS = 1'b0;
`endif

   localparam int M_FETCH = 0;
   localparam int M_EXEC  = 1;
   localparam int M_HALT  = 2;
   localparam int M_ERROR = 3;
   localparam int M_PAUSE = 4;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic [3:0] F = 4'h0;
   logic       N = 1'b0;
   logic       Z = 1'b0;
   logic       Mem_Rdy = 1'b0;
   logic       Step = 1'b0;
   logic       X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En;
   logic [1:0] M;
   logic       Rd, Wr, Halted, Bus_Err;

   int checkCount = 0;
   int errorCount = 0;
   int modelState = M_FETCH;
   int modelWait = 0;
   string tagQ[$];
   logic [11:0] expQ[$];

   mu0_control #(.TIMEOUT_CYCLES(TMO), .TO_W(TOW)) dut (
      .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .Mem_Rdy(Mem_Rdy),
`ifdef MU0_SINGLE_STEP_EN
      .Step(Step),
`endif
      .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel), .PC_En(PC_En),
      .IR_En(IR_En), .Acc_En(Acc_En), .M(M), .Rd(Rd), .Wr(Wr),
      .Halted(Halted), .Bus_Err(Bus_Err)
   );

   // Free-running clock: rising edges at 5, 15, 25 ...
   always #5 Clk = ~Clk;

   // Expected output vector {X_sel,Y_sel,Addr_sel,PC_En,IR_En,Acc_En,M,Rd,Wr,Halted,Bus_Err}.
   function automatic logic [11:0] modelOut(input int st, input logic [3:0] f,
                                            input logic n, input logic z, input logic rdy);
      logic xs, ys, as, pc, ir, acc, rd, wr, h, be;
      logic [1:0] m;
      {xs, ys, as, pc, ir, acc, rd, wr, h, be} = '0;
      m = 2'b00;
      if (st == M_FETCH) begin
         rd = 1; xs = 1; m = 2'b10; ir = rdy; pc = rdy;
      end else if (st == M_EXEC) begin
         if (f == 4'd0) begin as = 1; rd = 1; ys = 1; acc = rdy; end
         else if (f == 4'd1) begin as = 1; wr = 1; end
         else if (f == 4'd2) begin as = 1; rd = 1; ys = 1; m = 2'b01; acc = rdy; end
         else if (f == 4'd3) begin as = 1; rd = 1; ys = 1; m = 2'b11; acc = rdy; end
         else if (f == 4'd4) pc = 1;
         else if (f == 4'd5) pc = ~n;
         else if (f == 4'd6) pc = ~z;
      end else if (st == M_HALT) begin
         h = 1;
      end else if (st == M_ERROR) begin
         be = 1;
      end
      return {xs, ys, as, pc, ir, acc, m, rd, wr, h, be};
   endfunction

   function automatic logic [11:0] dutOut();
      return {X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, M, Rd, Wr, Halted, Bus_Err};
   endfunction

   // Advance the model across one rising edge with the given inputs.
   task automatic modelStep(input logic [3:0] f, input logic rdy, input logic step);
      int nxt;
      int doneSt;
      bit waiting;
      nxt = modelState;
      waiting = 0;
      doneSt = SS ? M_PAUSE : M_FETCH;
      if (modelState == M_FETCH) begin
         if (rdy) nxt = M_EXEC; else waiting = 1;
      end else if (modelState == M_EXEC) begin
         if (f <= 4'd3) begin
            if (rdy) nxt = doneSt; else waiting = 1;
         end else if (f == 4'd7) begin
            nxt = M_HALT;
         end else begin
            nxt = doneSt;
         end
      end else if (modelState == M_PAUSE) begin
         if (step) nxt = M_FETCH;
      end
      if (waiting) begin
         modelWait = modelWait + 1;
         if (TMO != 0 && modelWait >= TMO) nxt = M_ERROR;
      end
      if (nxt != modelState || !waiting) modelWait = 0;
      modelState = nxt;
   endtask

   task automatic checkOutput(input string tag, input logic [11:0] observed,
                              input logic [11:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s @%0t: got %b expected %b", tag, $time, observed, expected);
      end
   endtask

   // Pop the oldest prediction and compare it with the settled DUT outputs.
   task automatic scoreOne();
      string t;
      logic [11:0] e;
      t = tagQ.pop_front();
      e = expQ.pop_front();
      checkOutput(t, dutOut(), e);
   endtask

   // Drive one cycle at the falling edge, predict, check before the rising edge.
   task automatic applyStimulus(input string tag, input logic [3:0] f, input logic n,
                                input logic z, input logic rdy, input logic step);
      @(negedge Clk);
      F = f; N = n; Z = z; Mem_Rdy = rdy; Step = step;
      tagQ.push_back(tag);
      expQ.push_back(modelOut(modelState, f, n, z, rdy));
      #4;
      scoreOne();
      modelStep(f, rdy, step);
   endtask

   // Asynchronous reset between edges; released just after a rising edge.
   task automatic resetPulse(input string tag);
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      modelState = M_FETCH;
      modelWait = 0;
      tagQ.push_back(tag);
      expQ.push_back(modelOut(M_FETCH, F, N, Z, Mem_Rdy));
      scoreOne();
      @(posedge Clk);
      #1;
      tagQ.push_back({tag, "_hold"});
      expQ.push_back(modelOut(M_FETCH, F, N, Z, Mem_Rdy));
      scoreOne();
      Reset = 1'b1;
   endtask

   // Fetch + execute with memory always ready; in step builds, release PAUSE.
   task automatic runInstr(input string tag, input logic [3:0] f, input logic n, input logic z);
      applyStimulus({tag, "_fetch"}, f, n, z, 1'b1, 1'b0);
      applyStimulus({tag, "_exec"}, f, n, z, 1'b1, 1'b0);
      if (SS) applyStimulus({tag, "_step"}, f, n, z, 1'b1, 1'b1);
   endtask

   initial begin
      $display("[TB] mu0_control bench start (single-step=%0d)", SS);

      // Reset with memory idle: FETCH decode, no enables.
      Mem_Rdy = 1'b0;
      resetPulse("reset");

      // Short program: LDA, ADD, STA, STP, then HALT must persist.
      runInstr("lda", 4'd0, 1'b0, 1'b0);
      runInstr("add", 4'd2, 1'b0, 1'b0);
      runInstr("sta", 4'd1, 1'b0, 1'b0);
      runInstr("stp", 4'd7, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         applyStimulus("halt_stay", 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b1, 1'b1);

      // Conditional and unconditional jumps, SUB, NOPs.
      resetPulse("reset_jumps");
      runInstr("jge_n1", 4'd5, 1'b1, 1'b0);
      runInstr("jge_n0", 4'd5, 1'b0, 1'b0);
      runInstr("jne_z1", 4'd6, 1'b0, 1'b1);
      runInstr("jne_z0", 4'd6, 1'b0, 1'b0);
      runInstr("jmp", 4'd4, 1'b1, 1'b1);
      runInstr("sub", 4'd3, 1'b0, 1'b0);
      runInstr("nop8", 4'd8, 1'b0, 1'b0);
      runInstr("nopf", 4'd15, 1'b0, 1'b0);

      // Jumps ignore Mem_Rdy.
      applyStimulus("jmp_nordy_fetch", 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus("jmp_nordy_exec", 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      if (SS) applyStimulus("jmp_nordy_step", 4'd4, 1'b0, 1'b0, 1'b0, 1'b1);

      // Fetch stalls three cycles, then completes.
      for (int i = 0; i < 3; i++)
         applyStimulus("fetch_wait", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus("fetch_go", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus("lda_exec", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (SS) applyStimulus("lda_step", 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);

      // Mem_Rdy arrives on the threshold cycle: access completes normally.
      applyStimulus("edge_fetch", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < TMO - 1; i++)
         applyStimulus("edge_wait", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus("edge_rdy", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus("edge_next", 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus("edge_next2", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Reset mid-ADD while it waits on memory.
      resetPulse("reset_pre_add");
      applyStimulus("add_fetch", 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         applyStimulus("add_wait", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      resetPulse("reset_mid_add");
      applyStimulus("after_reset", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);

      // Watchdog expiry during LDA: ERROR is sticky until reset.
      resetPulse("reset_pre_to");
      applyStimulus("to_fetch", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < TMO; i++)
         applyStimulus("to_wait", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++)
         applyStimulus("error_stay", 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);

      // Watchdog expiry during a stalled fetch.
      resetPulse("reset_pre_fto");
      for (int i = 0; i < TMO + 2; i++)
         applyStimulus("fetch_to", 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef MU0_SINGLE_STEP_EN
      // Stall in PAUSE, then a one-cycle Step releases exactly one instruction.
      resetPulse("reset_ss");
      applyStimulus("ss_fetch", 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus("ss_exec", 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         applyStimulus("ss_pause", 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus("ss_pulse", 4'd9, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus("ss_fetch2", 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus("ss_exec2", 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         applyStimulus("ss_pause2", 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

      // Random traffic with periodic resets to escape HALT/ERROR.
      for (int i = 0; i < 300; i++) begin
         if (i % 50 == 0) resetPulse("reset_rand");
         applyStimulus("rand", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      errorCount++;
      $display("[TB] FAIL timeout: simulation did not finish by %0t", $time);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $fatal(1, "[TB] time limit reached");
   end

endmodule
